// File: rtl/i2s_rx_deser_if.sv
// I2S receiver pin/sample bundle: serial WS/SD in, parallel sample plus status out.
// slave = receiver side, master = pin driver / sample consumer side.
interface i2s_rx_deser_if #(
  parameter int PKT_WIDTH = 16
);
  logic                        ws_i;
  logic                        sd_i;
  logic signed [PKT_WIDTH-1:0] pkt_o;
  logic                        pktChanged_o;
  logic                        locked_o;
  logic                        frameErr_o;

  modport slave (
    input  ws_i, sd_i,
    output pkt_o, pktChanged_o, locked_o, frameErr_o
  );

  modport master (
    output ws_i, sd_i,
    input  pkt_o, pktChanged_o, locked_o, frameErr_o
  );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S serial-to-parallel receiver in the bit-clock domain: locks to WS, emits one sample per frame.
// Build option I2S_RX_MONO_SUM_EN: output floor((L+R)/2) after the right slot instead of the left word.
module i2s_rx_deser #(
  parameter int PKT_WIDTH  = 16,
  parameter int SLOT_WIDTH = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  i2s_rx_deser_if.slave bus
);
  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LSB  = CNT_W'(PKT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PKT  = CNT_W'(PKT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_WIDTH);

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            bitCnt;
  logic                        wsQ;
  logic [PKT_WIDTH-2:0]        shiftReg;
  logic signed [PKT_WIDTH-1:0] word_p0;
  logic                        vld_p0;

  logic                        wsEdge, wsFall, wsRise;
  logic                        inSlot, goodEdge, frameBad, lsbHere;
  logic signed [PKT_WIDTH-1:0] rxWord;

`ifdef I2S_RX_MONO_SUM_EN
  logic signed [PKT_WIDTH-1:0] leftHold;
  logic                        leftOk;

  function automatic logic signed [PKT_WIDTH-1:0] monoMean(
    input logic signed [PKT_WIDTH-1:0] l,
    input logic signed [PKT_WIDTH-1:0] r
  );
    logic signed [PKT_WIDTH:0] s;
    s = (PKT_WIDTH+1)'(l) + (PKT_WIDTH+1)'(r);
    return s[PKT_WIDTH:1];
  endfunction
`endif

  assign wsEdge   = bus.ws_i ^ wsQ;
  assign wsFall   = wsQ & ~bus.ws_i;
  assign wsRise   = ~wsQ & bus.ws_i;
  assign inSlot   = (state != UNLOCKED);
  assign goodEdge = (bitCnt == CNT_LAST) &&
                    (((state == LEFT) && wsRise) || ((state == RIGHT) && wsFall));
  // Any unexpected edge, or the count running past the slot end, breaks alignment.
  assign frameBad = inSlot && (wsEdge ? !goodEdge : (bitCnt == CNT_SAT));
  assign lsbHere  = inSlot && (bitCnt == CNT_LSB) && !frameBad;
  assign rxWord   = {shiftReg, bus.sd_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= UNLOCKED;
      bitCnt           <= '0;
      wsQ              <= bus.ws_i;
      shiftReg         <= '0;
      word_p0          <= '0;
      vld_p0           <= 1'b0;
      bus.pkt_o        <= '0;
      bus.pktChanged_o <= 1'b0;
      bus.locked_o     <= 1'b0;
      bus.frameErr_o   <= 1'b0;
`ifdef I2S_RX_MONO_SUM_EN
      leftHold         <= '0;
      leftOk           <= 1'b0;
`endif
    end else begin
      wsQ <= bus.ws_i;
      if (inSlot && (bitCnt < CNT_PKT))
        shiftReg <= rxWord[PKT_WIDTH-2:0];

      // p0 -> output: a pending word is dropped if its slot turns out bad this cycle
      bus.pktChanged_o <= vld_p0 && !frameBad;
      if (vld_p0 && !frameBad)
        bus.pkt_o <= word_p0;

      // LSB sample -> p0
      vld_p0 <= 1'b0;
`ifdef I2S_RX_MONO_SUM_EN
      if (lsbHere && (state == LEFT)) begin
        leftHold <= rxWord;
        leftOk   <= bus.locked_o;
      end
      if (lsbHere && (state == RIGHT) && leftOk) begin
        word_p0 <= monoMean(leftHold, rxWord);
        vld_p0  <= 1'b1;
      end
`else
      if (lsbHere && (state == LEFT) && bus.locked_o) begin
        word_p0 <= rxWord;
        vld_p0  <= 1'b1;
      end
`endif

      if (frameBad) begin
        bus.frameErr_o <= 1'b1;
        bus.locked_o   <= 1'b0;
        bitCnt         <= '0;
        // A falling offender is itself a valid left-slot start.
        state          <= wsFall ? LEFT : UNLOCKED;
`ifdef I2S_RX_MONO_SUM_EN
        leftOk         <= 1'b0;
`endif
      end else begin
        case (state)
          UNLOCKED: begin
            if (wsFall) begin
              state  <= LEFT;
              bitCnt <= '0;
            end
          end
          LEFT: begin
            if (goodEdge) begin
              state  <= RIGHT;
              bitCnt <= '0;
            end else if (bitCnt != CNT_SAT) begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          RIGHT: begin
            if (goodEdge) begin
              state        <= LEFT;
              bitCnt       <= '0;
              bus.locked_o <= 1'b1;
            end else if (bitCnt != CNT_SAT) begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: directed plus randomized I2S slot streams, checked every cycle
// against a slot-timing reference model, for SLOT_WIDTH 16 and 24.
module tb_i2s_rx_deser;
  localparam int PKT  = 16;
  localparam int MAXN = 2000;

  logic clk;
  logic rstA, rstB;

  i2s_rx_deser_if #(.PKT_WIDTH(PKT)) ifA ();
  i2s_rx_deser_if #(.PKT_WIDTH(PKT)) ifB ();

  i2s_rx_deser #(.PKT_WIDTH(PKT), .SLOT_WIDTH(16)) dutA (
    .clk_i(clk), .rst_i(rstA), .bus(ifA)
  );
  i2s_rx_deser #(.PKT_WIDTH(PKT), .SLOT_WIDTH(24)) dutB (
    .clk_i(clk), .rst_i(rstB), .bus(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit          sWs [MAXN];
  bit          sSd [MAXN];
  bit          sRst[MAXN];
  logic [15:0] eP  [MAXN];
  bit          eC  [MAXN];
  bit          eL  [MAXN];
  bit          eE  [MAXN];
  int          n;
  bit          lastPol;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

`ifdef I2S_RX_MONO_SUM_EN
  function automatic logic [15:0] meanRef(input logic [15:0] l, input logic [15:0] r);
    int s;
    s = int'($signed(l)) + int'($signed(r));
    return 16'(s >>> 1);
  endfunction
`endif

  task automatic clearStim();
    n = 0;
    lastPol = 1'b1;
    for (int i = 0; i < MAXN; i++) begin
      sWs[i] = 1'b0; sSd[i] = 1'b1; sRst[i] = 1'b0;
    end
  endtask

  task automatic addIdle(input int len, input bit wsv, input bit rstv);
    for (int i = 0; i < len && n < MAXN; i++) begin
      sWs[n] = wsv; sRst[n] = rstv; n++;
    end
    lastPol = wsv;
  endtask

  // A slot starting at index k carries its MSB at k+1 and LSB at k+PKT; padding stays 1.
  task automatic addSlot(input int len, input bit pol, input logic [15:0] w);
    int k;
    k = n;
    for (int i = 0; i < len && n < MAXN; i++) begin
      sWs[n] = pol; n++;
    end
    for (int j = 0; j < PKT; j++)
      if (k + 1 + j < MAXN) sSd[k + 1 + j] = w[15 - j];
    lastPol = pol;
  endtask

  task automatic addFrame(input int slot, input logic [15:0] l, input logic [15:0] r);
    addSlot(slot, 1'b0, l);
    addSlot(slot, 1'b1, r);
  endtask

  task automatic addRandom(input int slot, input int count);
    int r, len;
    bit pol;
    pol = !lastPol;
    for (int s = 0; s < count; s++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      len = slot;
      else if (r < 87) len = slot - 1 - $urandom_range(0, 3);
      else             len = slot + 1 + $urandom_range(0, 4);
      if ($urandom_range(0, 99) < 4 && n + 4 < MAXN) sRst[n + $urandom_range(1, 3)] = 1'b1;
      addSlot(len, pol, 16'($urandom));
      pol = !pol;
    end
  endtask

  // Reference: track where the current slot began and judge each WS edge by its
  // distance from that start; words are assembled from the sampled SD positions.
  task automatic runModel(input int slot);
    int mode, start, el;
    bit lk, fe, chg, wsPrev, pend, leftOk, edgeNow, fall, bad;
    logic [15:0] pOut, pendW, leftW, w;
    mode = 0; start = 0; lk = 0; fe = 0; chg = 0; wsPrev = 0;
    pend = 0; leftOk = 0; pOut = '0; pendW = '0; leftW = '0;
    for (int t = 0; t < n; t++) begin
      if (sRst[t]) begin
        mode = 0; lk = 0; fe = 0; chg = 0; pOut = '0; pend = 0; leftOk = 0;
        wsPrev = sWs[t];
      end else begin
        edgeNow = (sWs[t] != wsPrev);
        fall    = edgeNow && !sWs[t];
        el      = t - start;
        bad     = 1'b0;
        if (mode != 0)
          bad = edgeNow ? !(el == slot && sWs[t] == (mode == 1)) : (el == slot + 1);
        chg = pend && !bad;
        if (chg) pOut = pendW;
        pend = 1'b0;
        if (mode != 0 && !bad && el == PKT) begin
          w = '0;
          for (int j = 0; j < PKT; j++) w = {w[14:0], sSd[start + 1 + j]};
`ifdef I2S_RX_MONO_SUM_EN
          if (mode == 1) begin
            leftOk = lk; leftW = w;
          end else if (leftOk) begin
            pend = 1'b1; pendW = meanRef(leftW, w); leftOk = 1'b0;
          end
`else
          if (mode == 1 && lk) begin
            pend = 1'b1; pendW = w;
          end
`endif
        end
        if (bad) begin
          fe = 1'b1; lk = 1'b0; leftOk = 1'b0;
          mode = fall ? 1 : 0;
          start = t;
        end else if (mode == 0) begin
          if (fall) begin mode = 1; start = t; end
        end else if (edgeNow) begin
          if (mode == 2) lk = 1'b1;
          mode = (mode == 1) ? 2 : 1;
          start = t;
        end
        wsPrev = sWs[t];
      end
      eP[t] = pOut; eC[t] = chg; eL[t] = lk; eE[t] = fe;
    end
  endtask

  task automatic drive(input bit isB, input int t);
    if (!isB) begin
      rstA = sRst[t]; ifA.ws_i = sWs[t]; ifA.sd_i = sSd[t];
      rstB = 1'b1;    ifB.ws_i = 1'b0;   ifB.sd_i = 1'b0;
    end else begin
      rstB = sRst[t]; ifB.ws_i = sWs[t]; ifB.sd_i = sSd[t];
      rstA = 1'b1;    ifA.ws_i = 1'b0;   ifA.sd_i = 1'b0;
    end
  endtask

  task automatic runPhase(input bit isB, input int slot, input logic [15:0] firstExp);
    logic [15:0] p;
    bit c, l, e, seenFirst;
    string nm;
    nm = isB ? "B" : "A";
    seenFirst = 1'b0;
    runModel(slot);
    drive(isB, 0);
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      if (!isB) begin
        p = $unsigned(ifA.pkt_o); c = ifA.pktChanged_o; l = ifA.locked_o; e = ifA.frameErr_o;
      end else begin
        p = $unsigned(ifB.pkt_o); c = ifB.pktChanged_o; l = ifB.locked_o; e = ifB.frameErr_o;
      end
      checkEq($sformatf("%s.pkt@%0d", nm, t), int'(p), int'(eP[t]));
      checkEq($sformatf("%s.chg@%0d", nm, t), int'(c), int'(eC[t]));
      checkEq($sformatf("%s.lock@%0d", nm, t), int'(l), int'(eL[t]));
      checkEq($sformatf("%s.err@%0d", nm, t), int'(e), int'(eE[t]));
      if (sRst[t])
        checkEq($sformatf("%s.rstState@%0d", nm, t), int'({p, c, l, e}), 0);
      if (c && !seenFirst) begin
        checkEq($sformatf("%s.firstPkt", nm), int'(p), int'(firstExp));
        seenFirst = 1'b1;
      end
      if (t + 1 < n) drive(isB, t + 1);
    end
    checkEq($sformatf("%s.sawStrobe", nm), int'(seenFirst), 1);
  endtask

  initial begin
    int rstAt;
    logic [15:0] firstA, firstB;
`ifdef I2S_RX_MONO_SUM_EN
    firstA = 16'hDF00;
`else
    firstA = 16'h1234;
`endif
    firstB = 16'h8001;
    rstA = 1'b1; rstB = 1'b1;
    ifA.ws_i = 1'b1; ifA.sd_i = 1'b0; ifB.ws_i = 1'b1; ifB.sd_i = 1'b0;

    clearStim();
    addIdle(4, 1'b1, 1'b1);
    addIdle(3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) addFrame(16, 16'h1234, 16'hABCD);
    addSlot(15, 1'b0, 16'($urandom));
    addSlot(16, 1'b1, 16'($urandom));
    for (int i = 0; i < 2; i++) addFrame(16, 16'($urandom), 16'($urandom));
    addSlot(40, 1'b0, 16'($urandom));
    addSlot(16, 1'b1, 16'($urandom));
    for (int i = 0; i < 2; i++) addFrame(16, 16'($urandom), 16'($urandom));
    rstAt = n + 7;
    addFrame(16, 16'($urandom), 16'($urandom));
    sRst[rstAt] = 1'b1;
    for (int i = 0; i < 3; i++) addFrame(16, 16'($urandom), 16'($urandom));
    addRandom(16, 40);
    addIdle(5, lastPol, 1'b0);
    runPhase(1'b0, 16, firstA);

    clearStim();
    addIdle(4, 1'b1, 1'b1);
    addIdle(3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) addFrame(24, 16'h8001, 16'h8001);
    addRandom(24, 40);
    addIdle(5, lastPol, 1'b0);
    runPhase(1'b1, 24, firstB);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Serial-to-parallel I2S receiver that feeds the chorus DSP chain: i2s pins -> i2s_rx_deser -> STF CDC FIFO write side (i2sRxPkt_i / pktI2SRxChanged_i).
- Runs entirely in the I2S bit-clock domain (1.4112 MHz = 32 bit clocks per 44.1 kHz frame).
- Locks to word-select (WS), shifts in one 16-bit signed sample per frame and emits it with a one-cycle strobe.
- Flags framing errors and resynchronises automatically.

Parameters:
- PKT_WIDTH, 16, sample width in bits.
- SLOT_WIDTH, 16, bit clocks per channel slot (clocks between WS edges); must be >= PKT_WIDTH.

Ports:
- clk_i  in  1  I2S bit clock (clkI2S); all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ws_i  in  1  I2S word select; 0 = left slot, 1 = right slot; changes on falling edge.
- sd_i  in  1  I2S serial data, MSB first, one-bit delay after WS edge.
- pkt_o  out  PKT_WIDTH  received sample, two's complement.
- pktChanged_o  out  1  one-cycle strobe: new pkt_o valid.
- locked_o  out  1  high while frame-aligned.
- frameErr_o  out  1  sticky framing-error flag; cleared only by rst_i.

Behaviour:
- Reset (rst_i high at a rising edge): pkt_o=0, pktChanged_o=0, locked_o=0, frameErr_o=0, state=UNLOCKED, bitCnt=0, wsQ=ws_i, shift registers=0.
- wsQ registers ws_i every cycle. WS edge at edge k means ws_i != wsQ at rising edge k.
- States: UNLOCKED, LEFT, RIGHT.
  - UNLOCKED: wait for a falling WS edge (wsQ=1, ws_i=0), then go to LEFT with bitCnt=0. Rising WS edges are ignored.
  - LEFT/RIGHT: for a slot starting at edge k, sd_i is sampled at edges k+1..k+PKT_WIDTH, MSB first, into the slot's shift register.
  - LEFT/RIGHT: bits at k+PKT_WIDTH+1..k+SLOT_WIDTH are ignored.
  - bitCnt increments every cycle in the slot and saturates at SLOT_WIDTH.
- Expected next WS edge is at k+SLOT_WIDTH. With the default SLOT_WIDTH=PKT_WIDTH=16, the LSB sample and the next WS edge occur on the same cycle; both are processed.
- LEFT -> RIGHT on a rising WS edge with bitCnt==SLOT_WIDTH-1 (its final count).
- RIGHT -> LEFT on a falling WS edge with the same condition. locked_o is set at the first RIGHT->LEFT transition (one full frame seen).
- Framing error conditions:
  - a WS edge arrives early (bitCnt < SLOT_WIDTH-1);
  - no WS edge arrives by the expected cycle (bitCnt reaches SLOT_WIDTH);
  - a WS edge has the wrong polarity for the state.
- Error response:
  - frameErr_o <= 1, locked_o <= 0, state <= UNLOCKED; the partial word is discarded and no strobe is issued.
  - If the offending edge is itself a falling edge, it is taken as the new LEFT start on the same cycle (no lost frame).
- Output (default build): when the left LSB is sampled at edge k+PKT_WIDTH, then at edge k+PKT_WIDTH+1 pkt_o <= left word and pktChanged_o=1 for exactly one cycle. Latency from the LSB sample is 1 clock.
- pkt_o holds its value between strobes. Output rate is exactly one strobe per frame. The right word is received and checked for framing but discarded.
- No strobe is issued while UNLOCKED, including for the first left word after reset. Strobes start with the left word of the frame that sets locked_o, i.e. from the second frame after the first falling WS edge.
- rst_i mid-word: the partial word is dropped and no strobe is issued. If pktChanged_o is high in the reset cycle, it is low on the next cycle.

Optional Feature:
- Macro: I2S_RX_MONO_SUM_EN.
- Defined:
  - The strobe moves to one cycle after the right LSB is sampled.
  - pkt_o = (L + R) >>> 1, computed as a PKT_WIDTH+1-bit signed sum with an arithmetic shift (floor rounding, never overflows).
  - Left word is held in a register until the right slot completes.
  - Framing error in the right slot: no strobe is issued for that frame.
- Undefined: left channel only, as in Behaviour; no sum hardware.

Test Plan:
- Reset, then 3 clean frames with L=16'h1234, R=16'hABCD:
  - locked_o rises on the second falling WS edge after reset.
  - Each locked frame gives pkt_o=16'h1234 with pktChanged_o high for exactly 1 cycle, 17 clocks after that frame's falling WS edge; exactly one strobe per frame.
- Same stimulus with I2S_RX_MONO_SUM_EN: pkt_o=16'hDF00 (-8448), strobe 17 clocks after the rising WS edge.
- Left slot of 15 clocks (early WS rise):
  - frameErr_o=1 and locked_o=0 the next cycle; no strobe for that frame.
  - After the next falling edge plus one complete frame, locked_o=1 and strobes resume with frameErr_o still 1.
- WS held low for 40 clocks: frameErr_o=1 at the 17th clock after the falling edge; no strobe for that frame; pkt_o unchanged.
- rst_i asserted for 1 cycle mid left slot: all outputs 0 next cycle; no strobe until a full frame is relocked; frameErr_o=0.
- SLOT_WIDTH=24, PKT_WIDTH=16, L=16'h8001:
  - pkt_o=16'h8001; the 8 padding bits are driven as 1s and ignored.
  - WS edges at 24-clock spacing give no error.
